// File: rtl/pmem_pkg.sv
// pmem_pkg: shared definitions for the handshaked pmem_slave memory model.
//   chan_state_t          - per-channel FSM state (IDLE, BUSY, RESP)
//   LAT_W                 - width of the per-channel latency counter
//   pmem_read/pmem_write  - word-granular backing-store access, same
//                           signatures as the host-side memory functions
//   pmem_rd_calls/_wr_calls - access counters, useful to observe that each
//                           operation touches memory exactly once
package pmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } chan_state_t;

    localparam int LAT_W = 4;

    // Word-addressed backing store; keys are 4-byte aligned byte addresses.
    logic [31:0] pmem_mem [logic [31:0]];
    int unsigned pmem_rd_calls = 0;
    int unsigned pmem_wr_calls = 0;

    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        pmem_rd_calls++;
        if (pmem_mem.exists(a))
            return pmem_mem[a];
        return 32'h0;
    endfunction

    // mask[3:0] selects bytes of the addressed word; mask[7:4] is always
    // zero for a 32-bit word and is ignored.
    function automatic void pmem_write(input logic [31:0] addr,
                                       input logic [31:0] data,
                                       input logic [7:0]  mask);
        logic [31:0] a;
        logic [31:0] w;
        a = {addr[31:2], 2'b00};
        w = pmem_mem.exists(a) ? pmem_mem[a] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (mask[i])
                w[8*i +: 8] = data[8*i +: 8];
        pmem_mem[a] = w;
        pmem_wr_calls++;
    endfunction

endpackage

// File: rtl/pmem_chan_ctrl.sv
// pmem_chan_ctrl: request/response FSM with fixed-latency counter for one
// memory channel.
//   clock, reset  - clock, synchronous active-high reset
//   req_valid     - request offered by master
//   req_ready     - channel idle, can accept
//   accept        - one-cycle pulse on the request handshake cycle
//   fire          - one-cycle pulse on the cycle whose closing edge performs
//                   the memory access (cnt==0 in BUSY)
//   resp_valid    - response held until resp_ready
//   resp_ready    - master takes the response
module pmem_chan_ctrl
    import pmem_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    output logic req_ready,
    output logic accept,
    output logic fire,
    output logic resp_valid,
    input  logic resp_ready
);

    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LAT - 1);

    chan_state_t      state, state_nxt;
    logic [LAT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        accept     = 1'b0;
        fire       = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                // No same-cycle re-accept: req_ready returns next cycle.
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/pmem_slave.sv
// pmem_slave: clocked, handshaked memory model with independent read and
// write channels, each with a fixed request-to-response latency.
//   clock, reset                     - clock, synchronous active-high reset
//   rd_req_valid/ready, rd_addr      - read request
//   rd_resp_valid/ready, rd_data     - read response (DATA_W bits)
//   wr_req_valid/ready, wr_addr,
//   wr_data, wr_strb                 - write request with byte enables
//   wr_resp_valid/ready              - write completion
// DATA_W is 32 or 64; a 64-bit access is two 32-bit word accesses
// (low word at the aligned address, high word at +4).
module pmem_slave
    import pmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [31:0]         rd_addr,
    output logic                rd_resp_valid,
    input  logic                rd_resp_ready,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    input  logic [31:0]         wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                wr_resp_valid,
    input  logic                wr_resp_ready
);

    localparam int          STRB_W     = DATA_W / 8;
    localparam int          NWORD      = DATA_W / 32;
    localparam logic [31:0] ALIGN_MASK = ~32'(STRB_W - 1);

    logic rd_accept, rd_fire, wr_accept, wr_fire;

    logic [31:0]       rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q, rd_data_q;
    logic [STRB_W-1:0] wr_strb_q;
    logic [31:0]       rd_base, wr_base;

    pmem_chan_ctrl #(.LAT(RD_LAT)) u_rd_ctrl (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (rd_req_valid),
        .req_ready  (rd_req_ready),
        .accept     (rd_accept),
        .fire       (rd_fire),
        .resp_valid (rd_resp_valid),
        .resp_ready (rd_resp_ready)
    );

    pmem_chan_ctrl #(.LAT(WR_LAT)) u_wr_ctrl (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (wr_req_valid),
        .req_ready  (wr_req_ready),
        .accept     (wr_accept),
        .fire       (wr_fire),
        .resp_valid (wr_resp_valid),
        .resp_ready (wr_resp_ready)
    );

    // Request fields are sampled only at accept, so the master may change
    // the bus freely while the operation is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (rd_accept)
                rd_addr_q <= rd_addr;
            if (wr_accept) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
                wr_strb_q <= wr_strb;
            end
        end
    end

    assign rd_base = rd_addr_q & ALIGN_MASK;
    assign wr_base = wr_addr_q & ALIGN_MASK;

    // Write is issued before read in the same block so a read completing
    // on the same edge as an overlapping write observes the new data.
    // A word whose strobe nibble is zero is skipped entirely.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            if (wr_fire)
                for (int w = 0; w < NWORD; w++)
                    if (wr_strb_q[4*w +: 4] != 4'h0)
                        pmem_write(wr_base + 32'(4*w), wr_data_q[32*w +: 32],
                                   {4'h0, wr_strb_q[4*w +: 4]});
            if (rd_fire)
                for (int w = 0; w < NWORD; w++)
                    rd_data_q[32*w +: 32] <= pmem_read(rd_base + 32'(4*w));
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pmem_slave.sv
// Bench for pmem_slave: a 32-bit instance (RD_LAT=2, WR_LAT=4) and a 64-bit
// instance (RD_LAT=3, WR_LAT=3) share the backing store and are exercised
// one at a time against a byte-addressed reference memory.
module tb_pmem_slave;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // instance A: 32-bit
    logic        a_rd_req_valid, a_rd_req_ready, a_rd_resp_valid, a_rd_resp_ready;
    logic [31:0] a_rd_addr, a_rd_data;
    logic        a_wr_req_valid, a_wr_req_ready, a_wr_resp_valid, a_wr_resp_ready;
    logic [31:0] a_wr_addr, a_wr_data;
    logic [3:0]  a_wr_strb;
    // instance B: 64-bit
    logic        b_rd_req_valid, b_rd_req_ready, b_rd_resp_valid, b_rd_resp_ready;
    logic [31:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic        b_wr_req_valid, b_wr_req_ready, b_wr_resp_valid, b_wr_resp_ready;
    logic [31:0] b_wr_addr;
    logic [63:0] b_wr_data;
    logic [7:0]  b_wr_strb;

    pmem_slave #(.DATA_W(32), .RD_LAT(2), .WR_LAT(4)) u_a (
        .clock(clock), .reset(reset),
        .rd_req_valid(a_rd_req_valid), .rd_req_ready(a_rd_req_ready), .rd_addr(a_rd_addr),
        .rd_resp_valid(a_rd_resp_valid), .rd_resp_ready(a_rd_resp_ready), .rd_data(a_rd_data),
        .wr_req_valid(a_wr_req_valid), .wr_req_ready(a_wr_req_ready), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .wr_strb(a_wr_strb),
        .wr_resp_valid(a_wr_resp_valid), .wr_resp_ready(a_wr_resp_ready)
    );

    pmem_slave #(.DATA_W(64), .RD_LAT(3), .WR_LAT(3)) u_b (
        .clock(clock), .reset(reset),
        .rd_req_valid(b_rd_req_valid), .rd_req_ready(b_rd_req_ready), .rd_addr(b_rd_addr),
        .rd_resp_valid(b_rd_resp_valid), .rd_resp_ready(b_rd_resp_ready), .rd_data(b_rd_data),
        .wr_req_valid(b_wr_req_valid), .wr_req_ready(b_wr_req_ready), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_strb(b_wr_strb),
        .wr_resp_valid(b_wr_resp_valid), .wr_resp_ready(b_wr_resp_ready)
    );

    int errs = 0;
    int checks = 0;

    // reference memory, one entry per byte; absent bytes read as zero
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [63:0] ref_read(input logic [31:0] addr, input int nb);
        logic [31:0] base;
        logic [63:0] d;
        base = addr & ~32'(nb - 1);
        d = '0;
        for (int i = 0; i < nb; i++)
            if (ref_mem.exists(base + 32'(i)))
                d[8*i +: 8] = ref_mem[base + 32'(i)];
        return d;
    endfunction

    function automatic void ref_write(input logic [31:0] addr, input logic [63:0] data,
                                      input logic [7:0] strb, input int nb);
        logic [31:0] base;
        base = addr & ~32'(nb - 1);
        for (int i = 0; i < nb; i++)
            if (strb[i])
                ref_mem[base + 32'(i)] = data[8*i +: 8];
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        pmem_pkg::pmem_write(addr, w, 8'h0F);
        for (int i = 0; i < 4; i++)
            ref_mem[addr + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdv(input bit sel);  return sel ? b_rd_resp_valid : a_rd_resp_valid; endfunction
    function automatic logic rdr(input bit sel);  return sel ? b_rd_req_ready  : a_rd_req_ready;  endfunction
    function automatic logic wrv(input bit sel);  return sel ? b_wr_resp_valid : a_wr_resp_valid; endfunction
    function automatic logic wrr(input bit sel);  return sel ? b_wr_req_ready  : a_wr_req_ready;  endfunction
    function automatic logic [63:0] rdd(input bit sel);
        return sel ? b_rd_data : {32'h0, a_rd_data};
    endfunction

    // read with bp cycles of response back-pressure
    task automatic do_read(input bit sel, input logic [31:0] addr, input int bp);
        int n;
        int unsigned rc0;
        logic [63:0] exp, d0;
        rc0 = pmem_pkg::pmem_rd_calls;
        exp = ref_read(addr, sel ? 8 : 4);
        check("rd_req_ready_idle", 64'(rdr(sel)), 64'd1);
        if (sel) begin b_rd_addr = addr; b_rd_req_valid = 1'b1; b_rd_resp_ready = (bp == 0); end
        else     begin a_rd_addr = addr; a_rd_req_valid = 1'b1; a_rd_resp_ready = (bp == 0); end
        tick();
        if (sel) begin b_rd_req_valid = 1'b0; b_rd_addr = $urandom; end
        else     begin a_rd_req_valid = 1'b0; a_rd_addr = $urandom; end
        n = 0;
        while (!rdv(sel) && n < 40) begin tick(); n++; end
        check("rd_latency", 64'(n), sel ? 64'd3 : 64'd2);
        d0 = rdd(sel);
        check("rd_data", d0, exp);
        for (int i = 0; i < bp; i++) begin
            tick();
            check("rd_hold_valid", 64'(rdv(sel)), 64'd1);
            check("rd_hold_data", rdd(sel), d0);
            check("rd_hold_req_ready", 64'(rdr(sel)), 64'd0);
        end
        if (sel) b_rd_resp_ready = 1'b1; else a_rd_resp_ready = 1'b1;
        tick();
        check("rd_resp_drop", 64'(rdv(sel)), 64'd0);
        check("rd_req_ready_after", 64'(rdr(sel)), 64'd1);
        check("rd_call_count", 64'(pmem_pkg::pmem_rd_calls - rc0), sel ? 64'd2 : 64'd1);
    endtask

    task automatic do_write(input bit sel, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb);
        int n, exp_calls;
        int unsigned wc0;
        logic [7:0] s;
        s = sel ? strb : {4'h0, strb[3:0]};
        exp_calls = 0;
        if (s[3:0] != 4'h0) exp_calls++;
        if (s[7:4] != 4'h0) exp_calls++;
        wc0 = pmem_pkg::pmem_wr_calls;
        check("wr_req_ready_idle", 64'(wrr(sel)), 64'd1);
        if (sel) begin b_wr_addr = addr; b_wr_data = data; b_wr_strb = s; b_wr_req_valid = 1'b1; b_wr_resp_ready = 1'b1; end
        else     begin a_wr_addr = addr; a_wr_data = data[31:0]; a_wr_strb = s[3:0]; a_wr_req_valid = 1'b1; a_wr_resp_ready = 1'b1; end
        tick();
        if (sel) begin b_wr_req_valid = 1'b0; b_wr_data = {$urandom, $urandom}; b_wr_strb = 8'hFF; end
        else     begin a_wr_req_valid = 1'b0; a_wr_data = $urandom; a_wr_strb = 4'hF; end
        n = 0;
        while (!wrv(sel) && n < 40) begin tick(); n++; end
        check("wr_latency", 64'(n), sel ? 64'd3 : 64'd4);
        tick();
        check("wr_resp_drop", 64'(wrv(sel)), 64'd0);
        check("wr_req_ready_after", 64'(wrr(sel)), 64'd1);
        check("wr_call_count", 64'(pmem_pkg::pmem_wr_calls - wc0), 64'(exp_calls));
        ref_write(addr, data, s, sel ? 8 : 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        int unsigned wc0;
        bit sel;
        logic [31:0] addr;

        reset = 1'b1;
        a_rd_req_valid = 0; a_rd_resp_ready = 1; a_rd_addr = '0;
        a_wr_req_valid = 0; a_wr_resp_ready = 1; a_wr_addr = '0; a_wr_data = '0; a_wr_strb = '0;
        b_rd_req_valid = 0; b_rd_resp_ready = 1; b_rd_addr = '0;
        b_wr_req_valid = 0; b_wr_resp_ready = 1; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;
        repeat (3) tick();

        // reset state
        check("rst_a_rd_req_ready", 64'(a_rd_req_ready), 64'd1);
        check("rst_a_wr_req_ready", 64'(a_wr_req_ready), 64'd1);
        check("rst_a_rd_resp_valid", 64'(a_rd_resp_valid), 64'd0);
        check("rst_a_wr_resp_valid", 64'(a_wr_resp_valid), 64'd0);
        check("rst_a_rd_data", 64'(a_rd_data), 64'd0);
        check("rst_b_rd_req_ready", 64'(b_rd_req_ready), 64'd1);
        check("rst_b_wr_resp_valid", 64'(b_wr_resp_valid), 64'd0);
        check("rst_b_rd_data", b_rd_data, 64'd0);
        reset = 1'b0;
        tick();

        // single read, latency and exactly-one response cycle
        preload(32'h8000_0000, 32'hDEAD_BEEF);
        do_read(1'b0, 32'h8000_0000, 0);
        check("t1_data_const", 64'(a_rd_data), 64'h0000_0000_DEAD_BEEF);

        // partial write then read-back
        preload(32'h8000_0010, 32'hAABB_CCDD);
        do_write(1'b0, 32'h8000_0010, 64'h1122_3344, 8'h05);
        do_read(1'b0, 32'h8000_0010, 0);
        check("t2_merge_const", 64'(a_rd_data), 64'h0000_0000_AA22_CC44);

        // zero strobe: completes, no memory call
        do_write(1'b0, 32'h8000_0010, 64'hFFFF_FFFF, 8'h00);
        do_read(1'b0, 32'h8000_0010, 0);

        // read back-pressure
        do_read(1'b0, 32'h8000_0010, 4);

        // 64-bit read, unaligned address
        preload(32'h8000_0000, 32'h1111_1111);
        preload(32'h8000_0004, 32'h2222_2222);
        do_read(1'b1, 32'h8000_0004, 0);
        check("t4_data_const", b_rd_data, 64'h2222_2222_1111_1111);

        // 64-bit write touching only the high half
        do_write(1'b1, 32'h8000_0000, 64'hCAFE_F00D_0BAD_0BAD, 8'hF0);
        do_read(1'b1, 32'h8000_0000, 1);

        // concurrent same-address completion on the 64-bit instance
        preload(32'h8000_0020, 32'h0101_0101);
        preload(32'h8000_0024, 32'h0202_0202);
        b_rd_addr = 32'h8000_0020; b_rd_req_valid = 1'b1; b_rd_resp_ready = 1'b1;
        b_wr_addr = 32'h8000_0020; b_wr_data = 64'hC3C3_C3C3_5A5A_5A5A; b_wr_strb = 8'hFF;
        b_wr_req_valid = 1'b1; b_wr_resp_ready = 1'b1;
        tick();
        b_rd_req_valid = 1'b0; b_wr_req_valid = 1'b0;
        n = 0;
        while (!b_rd_resp_valid && n < 40) begin tick(); n++; end
        check("t5_rd_latency", 64'(n), 64'd3);
        check("t5_wr_valid_same_cycle", 64'(b_wr_resp_valid), 64'd1);
        check("t5_rd_sees_write", b_rd_data, 64'hC3C3_C3C3_5A5A_5A5A);
        ref_write(32'h8000_0020, 64'hC3C3_C3C3_5A5A_5A5A, 8'hFF, 8);
        tick();
        check("t5_rd_ready_after", 64'(b_rd_req_ready), 64'd1);
        check("t5_wr_ready_after", 64'(b_wr_req_ready), 64'd1);

        // reset while a write is pending
        preload(32'h8000_0040, 32'h0BAD_F00D);
        wc0 = pmem_pkg::pmem_wr_calls;
        a_wr_addr = 32'h8000_0040; a_wr_data = 32'hFFFF_FFFF; a_wr_strb = 4'hF;
        a_wr_req_valid = 1'b1; a_wr_resp_ready = 1'b1;
        tick();
        a_wr_req_valid = 1'b0;
        seen = 0;
        repeat (2) begin tick(); if (a_wr_resp_valid) seen++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rd_req_ready", 64'(a_rd_req_ready), 64'd1);
        check("t6_wr_req_ready", 64'(a_wr_req_ready), 64'd1);
        check("t6_rd_data_cleared", 64'(a_rd_data), 64'd0);
        repeat (8) begin tick(); if (a_wr_resp_valid) seen++; end
        check("t6_no_wr_resp", 64'(seen), 64'd0);
        check("t6_no_wr_call", 64'(pmem_pkg::pmem_wr_calls - wc0), 64'd0);
        do_read(1'b0, 32'h8000_0040, 0);

        // randomized traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            sel  = 1'($urandom_range(0, 1));
            addr = 32'h8000_0100 + (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 1) == 1)
                do_write(sel, addr, {$urandom, $urandom}, 8'($urandom));
            else
                do_read(sel, addr, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
